// File: rtl/registers_bank.sv
// ============================================================================
// Module   : registers_bank
// Brief    : 2**ADDR_W x DATA_W register file, two combinational read ports,
//            one synchronous write port, synchronous active-high clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module registers_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] data,
  input  logic              write,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b
);

  localparam int C_NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [C_NREG];

  // Each register owns its own flop group, so only the addressed one loads.
  // Reset wins over write; R0 is ordinary storage.
  for (genvar gi = 0; gi < C_NREG; gi++) begin : g_reg
    logic w_we;
    assign w_we = write && (addr_d == ADDR_W'(gi));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_regs[gi] <= '0;
      end else if (w_we) begin
        r_regs[gi] <= data;
      end
    end
  end

  // No write-to-read bypass: reads reflect current register contents only.
  assign a = r_regs[addr_a];
  assign b = r_regs[addr_b];

endmodule

`default_nettype wire

// File: tb/tb_registers_bank.sv
// ============================================================================
// Module   : tb_registers_bank
// Brief    : Directed self-checking bench for registers_bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_registers_bank;

  logic        clk;
  logic        reset;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [4:0]  addr_d;
  logic [31:0] data;
  logic        write;
  logic [31:0] a;
  logic [31:0] b;

  int n_cmp;
  int n_err;

  registers_bank #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .addr_d (addr_d),
    .data   (data),
    .write  (write),
    .a      (a),
    .b      (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b1;
    write  = 1'b1;
    addr_d = 5'd0;
    data   = 32'h0000_0001;
    addr_a = 5'd1;
    addr_b = 5'd2;

    // Reset has priority over a simultaneous write to R0.
    tick();
    check("rst_a", a, 32'h0);
    check("rst_b", b, 32'h0);
    addr_a = 5'd0;
    addr_b = 5'd31;
    #1;
    check("rst_r0", a, 32'h0);
    check("rst_r31", b, 32'h0);

    // Write R0; R0 is ordinary storage.
    reset  = 1'b0;
    write  = 1'b1;
    addr_d = 5'd0;
    data   = 32'h0000_0001;
    tick();
    write  = 1'b0;
    data   = 32'h0000_0003;
    addr_a = 5'd0;
    addr_b = 5'd0;
    #1;
    check("r0_a", a, 32'h0000_0001);
    check("r0_b", b, 32'h0000_0001);
    tick();
    check("r0_hold", a, 32'h0000_0001);

    // Same-cycle read of the write target: old value before, new value after.
    write  = 1'b1;
    addr_d = 5'd1;
    data   = 32'h0000_0002;
    addr_a = 5'd1;
    addr_b = 5'd0;
    #1;
    check("nobypass_a", a, 32'h0);
    check("nobypass_b", b, 32'h0000_0001);
    tick();
    check("post_a", a, 32'h0000_0002);
    check("post_b", b, 32'h0000_0001);

    // Top-of-range addresses on consecutive edges.
    addr_d = 5'd31;
    data   = 32'hA5A5_A5A5;
    tick();
    addr_d = 5'd30;
    data   = 32'h5A5A_5A5A;
    tick();
    write  = 1'b0;
    addr_a = 5'd31;
    addr_b = 5'd30;
    #1;
    check("r31", a, 32'hA5A5_A5A5);
    check("r30", b, 32'h5A5A_5A5A);
    addr_a = 5'd1;
    addr_b = 5'd0;
    #1;
    check("r1_kept", a, 32'h0000_0002);
    check("r0_kept", b, 32'h0000_0001);

    // Pulse on write between edges must not change state.
    @(negedge clk);
    write  = 1'b1;
    addr_d = 5'd4;
    data   = 32'h1234_5678;
    #2;
    write  = 1'b0;
    tick();
    addr_a = 5'd4;
    #1;
    check("glitch_r4", a, 32'h0);

    // Reset between writes clears previously written values.
    write  = 1'b1;
    addr_d = 5'd5;
    data   = 32'hFFFF_FFFF;
    tick();
    write  = 1'b0;
    addr_a = 5'd5;
    #1;
    check("r5_written", a, 32'hFFFF_FFFF);
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    addr_b = 5'd31;
    #1;
    check("r5_cleared", a, 32'h0);
    check("r31_cleared", b, 32'h0);

    // write=0 with toggling data/address: R7 stays at reset value.
    write  = 1'b0;
    addr_d = 5'd7;
    addr_a = 5'd7;
    addr_b = 5'd0;
    for (int i = 0; i < 3; i++) begin
      data = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h2152_4110;
      tick();
    end
    check("r7_unchanged", a, 32'h0);
    check("r0_after_rst", b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
